// File: rtl/binary_mul_15_1_acc.sv
// Group accumulator for signed 15x15 multiplier products with a one-deep result holding stage.
// Define BINARY_MUL_ACC_SAT_EN to saturate each addition; otherwise additions wrap modulo 2^36.
module binary_mul_15_1_acc #(
    parameter int MAX_LEN = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [28:0] in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [35:0] out_data,
    output logic [7:0]  out_count,
    output logic        out_ovf
);

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [7:0] MAX_CNT = 8'(MAX_LEN);

    state_t      state;
    state_t      state_next;
    logic [35:0] acc;
    logic [7:0]  cnt;

    logic        in_fire;
    logic        out_fire;
    logic        first;
    logic [35:0] beat;
    logic [35:0] sum;
    logic [7:0]  cnt_inc;
    logic        at_max;
    logic        close;

    function automatic logic [35:0] add36(input logic [35:0] a, input logic [35:0] b);
`ifdef BINARY_MUL_ACC_SAT_EN
        logic [36:0] s;
        s = {a[35], a} + {b[35], b};
        if (s[36] != s[35]) begin
            add36 = s[36] ? 36'h8_0000_0000 : 36'h7_FFFF_FFFF;
        end else begin
            add36 = s[35:0];
        end
`else
        add36 = a + b;
`endif
    endfunction

    // Handshake, next-sum and group-close decode.
    always_comb begin
        in_ready = (state == ACC) ? 1'b1 : out_ready;
        in_fire  = en & in_valid & in_ready;
        out_fire = en & out_valid & out_ready;
        // cnt is cleared whenever a group closes, so zero marks a fresh group.
        first    = (cnt == 8'd0);
        beat     = {{7{in_data[28]}}, in_data};
        sum      = first ? beat : add36(acc, beat);
        cnt_inc  = first ? 8'd1 : (cnt + 8'd1);
        at_max   = (cnt_inc == MAX_CNT);
        close    = in_last | at_max;
    end

    // Next-state decode.
    always_comb begin
        state_next = state;
        if (in_fire && close) begin
            state_next = HOLD;
        end else if (out_fire) begin
            state_next = ACC;
        end else begin
            state_next = state;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ACC;
        end else begin
            state <= state_next;
        end
    end

    // Accumulator, counter and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= 36'd0;
            cnt       <= 8'd0;
            out_valid <= 1'b0;
            out_data  <= 36'd0;
            out_count <= 8'd0;
            out_ovf   <= 1'b0;
        end else if (in_fire) begin
            if (close) begin
                out_data  <= sum;
                out_count <= cnt_inc;
                out_ovf   <= at_max & ~in_last;
                out_valid <= 1'b1;
                acc       <= 36'd0;
                cnt       <= 8'd0;
            end else begin
                acc <= sum;
                cnt <= cnt_inc;
                if (out_fire) begin
                    out_valid <= 1'b0;
                end
            end
        end else if (out_fire) begin
            out_valid <= 1'b0;
            acc       <= 36'd0;
            cnt       <= 8'd0;
        end
    end

endmodule

// File: tb/tb_binary_mul_15_1_acc.sv
// Self-checking bench for binary_mul_15_1_acc: directed scenarios plus a randomized
// group stream scored against an arithmetic reference model.
module tb_binary_mul_15_1_acc;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        in_valid;
    logic        in_ready;
    logic [28:0] in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [35:0] out_data;
    logic [7:0]  out_count;
    logic        out_ovf;

    int n_cmp  = 0;
    int n_fail = 0;

    binary_mul_15_1_acc #(.MAX_LEN(128)) dut (
        .clk(clk), .rst(rst), .en(en),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_count(out_count), .out_ovf(out_ovf)
    );

    always #5 clk = ~clk;

    // Reference arithmetic on integers: sign-extend the product, then add with wrap or clamp.
    function automatic longint sx(input logic [28:0] d);
        return longint'($signed(d));
    endfunction

    function automatic longint m_add(input longint a, input longint b);
        longint s;
        s = a + b;
`ifdef BINARY_MUL_ACC_SAT_EN
        if (s > 64'sd34359738367)  s = 64'sd34359738367;
        if (s < -64'sd34359738368) s = -64'sd34359738368;
`else
        s = s & ((64'sd1 <<< 36) - 64'sd1);
        if (s >= (64'sd1 <<< 35)) s = s - (64'sd1 <<< 36);
`endif
        return s;
    endfunction

    function automatic logic [35:0] to36(input longint v);
        logic [63:0] t;
        t = 64'(v);
        return t[35:0];
    endfunction

    task automatic beat(input logic [28:0] d, input logic l);
        int n;
        n = 0;
        in_data = d; in_last = l; in_valid = 1'b1;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1; n++;
        end
        n_cmp++;
        if (n >= 200) begin
            n_fail++;
            $display("FAIL beat_accept: in_ready=%b after %0d cycles, required 1", in_ready, n);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = 29'd0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        beat(29'd77, 1'b1);
        n_cmp++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid: got %b want 1", out_valid); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        n_cmp++;
        if ({out_valid, out_data, out_count, out_ovf} !== 46'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b data=%0d count=%0d ovf=%b want all 0",
                     out_valid, $signed(out_data), out_count, out_ovf);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_basic();
        longint e;
        out_ready = 1'b1;
        e = m_add(m_add(sx(29'd100), sx(29'(-250))), sx(29'd7));
        beat(29'd100, 1'b0);
        beat(29'(-250), 1'b0);
        beat(29'd7, 1'b1);
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== to36(e) || out_count !== 8'd3 || out_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_group: valid=%b data=%0d count=%0d ovf=%b want 1 %0d 3 0",
                     out_valid, $signed(out_data), out_count, out_ovf, e);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drain: valid=%b want 0", out_valid); end
    endtask

    task automatic test_maxlen();
        longint e;
        logic [28:0] d;
        // 2^28 does not fit a signed 29-bit field; it is taken as -2^28 and sign-extended.
        d = 29'h1000_0000;
        out_ready = 1'b0;
        e = sx(d);
        for (int i = 1; i < 128; i++) e = m_add(e, sx(d));
        for (int i = 0; i < 128; i++) beat(d, 1'b0);
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== to36(e) || out_count !== 8'd128 || out_ovf !== 1'b1) begin
            n_fail++;
            $display("FAIL maxlen_ovf: valid=%b data=%0d count=%0d ovf=%b want 1 %0d 128 1",
                     out_valid, $signed(out_data), out_count, out_ovf, e);
        end
        n_cmp++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL maxlen_hold_ready: got %b want 0", in_ready); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        d = 29'($urandom_range(0, 1000));
        e = sx(d);
        for (int i = 1; i < 128; i++) e = m_add(e, sx(d));
        for (int i = 0; i < 128; i++) beat(d, (i == 127) ? 1'b1 : 1'b0);
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== to36(e) || out_count !== 8'd128 || out_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL maxlen_last: valid=%b data=%0d count=%0d ovf=%b want 1 %0d 128 0",
                     out_valid, $signed(out_data), out_count, out_ovf, e);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        beat(29'd9, 1'b1);
        in_valid = 1'b1; in_data = 29'd5; in_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== 36'd9 || out_count !== 8'd1) begin
                n_fail++;
                $display("FAIL bp_stable[%0d]: valid=%b data=%0d count=%0d want 1 9 1",
                         i, out_valid, $signed(out_data), out_count);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 36'd5 || out_count !== 8'd1 || out_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_back_to_back: valid=%b data=%0d count=%0d ovf=%b want 1 5 1 0",
                     out_valid, $signed(out_data), out_count, out_ovf);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: valid=%b want 0", out_valid); end
    endtask

    task automatic test_rst_mid();
        out_ready = 1'b1;
        beat(29'd50, 1'b0);
        beat(29'd60, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        beat(29'd1, 1'b0);
        beat(29'd2, 1'b1);
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 36'd3 || out_count !== 8'd2 || out_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_group: valid=%b data=%0d count=%0d ovf=%b want 1 3 2 0",
                     out_valid, $signed(out_data), out_count, out_ovf);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_en_gap();
        out_ready = 1'b1;
        beat(29'd11, 1'b0);
        beat(29'd22, 1'b0);
        en = 1'b0; in_valid = 1'b1; in_data = 29'd99; in_last = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL en_gap_accept[%0d]: valid=%b want 0", i, out_valid); end
        end
        in_valid = 1'b0; in_last = 1'b0; en = 1'b1;
        beat(29'd33, 1'b1);
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 36'd66 || out_count !== 8'd3) begin
            n_fail++;
            $display("FAIL en_gap_result: valid=%b data=%0d count=%0d want 1 66 3",
                     out_valid, $signed(out_data), out_count);
        end
        en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 36'd66) begin
            n_fail++;
            $display("FAIL en_gap_hold: valid=%b data=%0d want 1 66", out_valid, $signed(out_data));
        end
        en = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        longint q_sum[$];
        int     q_cnt[$];
        int     ngroups;
        int     rcv;
        ngroups = 40;
        rcv = 0;
        fork
            begin : drv
                longint s;
                int     len;
                int     n;
                logic   go;
                logic [28:0] d;
                for (int g = 0; g < ngroups; g++) begin
                    len = $urandom_range(1, 12);
                    for (int b = 0; b < len; b++) begin
                        if ($urandom_range(0, 3) == 0) begin
                            in_valid = 1'b0;
                            @(posedge clk); #2;
                        end
                        case ($urandom_range(0, 3))
                            0:       d = 29'h1000_0000;
                            1:       d = 29'h0FFF_FFFF;
                            default: d = 29'($urandom);
                        endcase
                        in_data = d; in_last = (b == len - 1); in_valid = 1'b1;
                        n = 0;
                        go = in_ready;
                        @(posedge clk);
                        while (!go && n < 500) begin
                            #2; go = in_ready; n++;
                            @(posedge clk);
                        end
                        if (n >= 500) begin
                            n_cmp++; n_fail++;
                            $display("FAIL rand_accept: beat %0d of group %0d never accepted", b, g);
                        end
                        s = (b == 0) ? sx(d) : m_add(s, sx(d));
                        if (b == len - 1) begin
                            q_sum.push_back(s);
                            q_cnt.push_back(len);
                        end
                        #2;
                    end
                end
                in_valid = 1'b0; in_last = 1'b0;
            end
            begin : chk
                int cyc;
                cyc = 0;
                while (rcv < ngroups && cyc < 4000) begin
                    @(posedge clk); #1;
                    cyc++;
                    out_ready = 1'($urandom_range(0, 1));
                    if (out_valid && out_ready) begin
                        n_cmp++;
                        if (q_sum.size() == 0) begin
                            n_fail++;
                            $display("FAIL rand_unexpected: data=%0d count=%0d with no group pending",
                                     $signed(out_data), out_count);
                        end else begin
                            if (out_data !== to36(q_sum[0]) || out_count !== 8'(q_cnt[0]) || out_ovf !== 1'b0) begin
                                n_fail++;
                                $display("FAIL rand_group[%0d]: data=%0d count=%0d ovf=%b want %0d %0d 0",
                                         rcv, $signed(out_data), out_count, out_ovf, q_sum[0], q_cnt[0]);
                            end
                            void'(q_sum.pop_front());
                            void'(q_cnt.pop_front());
                        end
                        rcv++;
                    end
                end
                n_cmp++;
                if (rcv < ngroups) begin
                    n_fail++;
                    $display("FAIL rand_timeout: received %0d groups, required %0d", rcv, ngroups);
                end
            end
        join
        out_ready = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic();
        test_maxlen();
        test_backpressure();
        test_rst_mid();
        test_en_gap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
